// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared pipeline definitions: operand-forward select codes and
//               the bit layout of a tracked destination-register entry.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  // Operand-mux select codes, in order of data age at the ALU input
  localparam logic [1:0] FWD_SEL_RF   = 2'd0;  // register file
  localparam logic [1:0] FWD_SEL_MEM  = 2'd1;  // EX/MEM ALU result
  localparam logic [1:0] FWD_SEL_WB   = 2'd2;  // MEM/WB result
  localparam logic [1:0] FWD_SEL_POST = 2'd3;  // post-WB holding register

  // Tracked entry layout: {rd, is_load, wr_en, valid}, rd in the top bits
  localparam int ENT_VALID   = 0;
  localparam int ENT_WR_EN   = 1;
  localparam int ENT_IS_LOAD = 2;
  localparam int ENT_RD_LSB  = 3;

  // Total entry width for a given register-address width
  function automatic int entry_width(input int rd_bits);
    return rd_bits + ENT_RD_LSB;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_stage_reg
// Description : One tracked pipeline entry. Clear wins over load; the entry
//               holds its value when neither is asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_stage_reg #(
  parameter int WIDTH = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] entry_in,
  output logic [WIDTH-1:0] entry_out
);

  logic [WIDTH-1:0] entry_q;
  logic [WIDTH-1:0] entry_d;

  // Next entry: clear kills, load captures, otherwise hold
  always_comb begin
    entry_d = entry_q;
    if (clear) begin
      entry_d = '0;
    end else if (load) begin
      entry_d = entry_in;
    end
  end

  // Entry register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_out = entry_q;

endmodule
`default_nettype wire

// File: rtl/forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : forward_ctrl
// Description : Operand-forwarding and load-use hazard controller for the
//               execute stage. Tracks EX/MEM/WB destination entries, produces
//               registered 2-bit operand-mux selects and a combinational
//               load-use stall.
//               Option macro FWD_POST_WB_EN: adds the POST entry and enables
//               select 3 for register files without write-through.
// Revision    : 1.0 - initial release
// ============================================================================
module forward_ctrl #(
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR_BITS-1:0] id_rs1,
  input  logic [REG_ADDR_BITS-1:0] id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic                     id_wr_en,
  input  logic [REG_ADDR_BITS-1:0] id_rd,
  input  logic                     id_is_load,
  input  logic                     ex_flush,
  output logic                     stall,
  output logic [1:0]               fwd_sel_a,
  output logic [1:0]               fwd_sel_b
);

  import pipeline_pkg::*;

  localparam int ENT_W = entry_width(REG_ADDR_BITS);

`ifdef FWD_POST_WB_EN
  localparam bit POST_EN = 1'b1;
`else
  localparam bit POST_EN = 1'b0;
`endif

  // An entry produces r when it is a live writer of r; r0 never forwards
  function automatic logic produces(
    input logic                     valid,
    input logic                     wr_en,
    input logic [REG_ADDR_BITS-1:0] rd,
    input logic [REG_ADDR_BITS-1:0] r
  );
    return valid & wr_en & (rd == r) & (r != '0);
  endfunction

  // Youngest producer wins; an unused source always reads the register file
  function automatic logic [1:0] pick_sel(
    input logic use_bit,
    input logic hit_ex,
    input logic hit_mem,
    input logic hit_wb
  );
    logic [1:0] sel;
    sel = FWD_SEL_RF;
    if (use_bit) begin
      if (hit_ex) begin
        sel = FWD_SEL_MEM;
      end else if (hit_mem) begin
        sel = FWD_SEL_WB;
      end else if (POST_EN && hit_wb) begin
        sel = FWD_SEL_POST;
      end
    end
    return sel;
  endfunction

  logic [ENT_W-1:0]         ex_q;
  logic [ENT_W-1:0]         mem_q;
  logic [ENT_W-1:0]         wb_q;
  logic [ENT_W-1:0]         id_entry;
  logic [REG_ADDR_BITS-1:0] ex_rd;
  logic                     load_hazard;
  logic                     issue;

  logic [REG_ADDR_BITS-1:0] src_rs  [2];
  logic                     src_use [2];
  logic [1:0]               src_sel [2];

  logic [1:0]               fwd_sel_a_q;
  logic [1:0]               fwd_sel_a_d;
  logic [1:0]               fwd_sel_b_q;
  logic [1:0]               fwd_sel_b_d;

  assign ex_rd = ex_q[ENT_RD_LSB +: REG_ADDR_BITS];

  // Load-use hazard: a load in EX whose rd a valid ID instruction reads
  always_comb begin
    load_hazard = id_valid & ex_q[ENT_VALID] & ex_q[ENT_IS_LOAD] &
                  ex_q[ENT_WR_EN] & (ex_rd != '0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) |
                   (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  // Flush overrides stall; only a surviving ID instruction enters EX
  assign stall = load_hazard & ~ex_flush;
  assign issue = id_valid & ~stall & ~ex_flush;

  // Decode-stage entry as it will appear in EX
  always_comb begin
    id_entry                                = '0;
    id_entry[ENT_VALID]                     = issue;
    id_entry[ENT_WR_EN]                     = id_wr_en;
    id_entry[ENT_IS_LOAD]                   = id_is_load;
    id_entry[ENT_RD_LSB +: REG_ADDR_BITS]   = id_rd;
  end

  // Stage tracking: EX takes ID (or a bubble), flush kills what leaves EX
  fwd_stage_reg #(.WIDTH(ENT_W)) u_ex (
    .clock     (clock),
    .reset     (reset),
    .load      (1'b1),
    .clear     (1'b0),
    .entry_in  (id_entry),
    .entry_out (ex_q)
  );

  fwd_stage_reg #(.WIDTH(ENT_W)) u_mem (
    .clock     (clock),
    .reset     (reset),
    .load      (1'b1),
    .clear     (ex_flush),
    .entry_in  (ex_q),
    .entry_out (mem_q)
  );

  fwd_stage_reg #(.WIDTH(ENT_W)) u_wb (
    .clock     (clock),
    .reset     (reset),
    .load      (1'b1),
    .clear     (1'b0),
    .entry_in  (mem_q),
    .entry_out (wb_q)
  );

`ifdef FWD_POST_WB_EN
  // POST mirrors the holding register that feeds select 3
  logic [ENT_W-1:0] post_q;
  logic             unused_post;

  fwd_stage_reg #(.WIDTH(ENT_W)) u_post (
    .clock     (clock),
    .reset     (reset),
    .load      (1'b1),
    .clear     (1'b0),
    .entry_in  (wb_q),
    .entry_out (post_q)
  );

  assign unused_post = ^post_q;
`else
  logic unused_wb_load;
  assign unused_wb_load = wb_q[ENT_IS_LOAD];
`endif

  assign src_rs[0]  = id_rs1;
  assign src_rs[1]  = id_rs2;
  assign src_use[0] = id_use_rs1;
  assign src_use[1] = id_use_rs2;

  // Per-source comparison against each tracked stage
  for (genvar s = 0; s < 2; s++) begin : g_src
    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    assign hit_ex  = produces(ex_q[ENT_VALID],  ex_q[ENT_WR_EN],
                              ex_q[ENT_RD_LSB +: REG_ADDR_BITS],  src_rs[s]);
    assign hit_mem = produces(mem_q[ENT_VALID], mem_q[ENT_WR_EN],
                              mem_q[ENT_RD_LSB +: REG_ADDR_BITS], src_rs[s]);
    assign hit_wb  = produces(wb_q[ENT_VALID],  wb_q[ENT_WR_EN],
                              wb_q[ENT_RD_LSB +: REG_ADDR_BITS],  src_rs[s]);
    assign src_sel[s] = pick_sel(src_use[s], hit_ex, hit_mem, hit_wb);
  end

  // Next selects: bubbles (invalid, stall, flush) read the register file
  always_comb begin
    fwd_sel_a_d = FWD_SEL_RF;
    fwd_sel_b_d = FWD_SEL_RF;
    if (issue) begin
      fwd_sel_a_d = src_sel[0];
      fwd_sel_b_d = src_sel[1];
    end
  end

  // Select registers, presented during the instruction's EX cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_sel_a_q <= FWD_SEL_RF;
      fwd_sel_b_q <= FWD_SEL_RF;
    end else begin
      fwd_sel_a_q <= fwd_sel_a_d;
      fwd_sel_b_q <= fwd_sel_b_d;
    end
  end

  assign fwd_sel_a = fwd_sel_a_q;
  assign fwd_sel_b = fwd_sel_b_q;

endmodule
`default_nettype wire

// File: tb/tb_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_ctrl
// Description : Directed self-checking bench for forward_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_ctrl;

  localparam int RB = 4;

`ifdef FWD_POST_WB_EN
  localparam logic [1:0] EXP_POST = 2'd3;
`else
  localparam logic [1:0] EXP_POST = 2'd0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [RB-1:0] id_rs1;
  logic [RB-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic          id_wr_en;
  logic [RB-1:0] id_rd;
  logic          id_is_load;
  logic          ex_flush;
  logic          stall;
  logic [1:0]    fwd_sel_a;
  logic [1:0]    fwd_sel_b;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  forward_ctrl #(.REG_ADDR_BITS(RB)) dut (
    .clock      (clock),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_wr_en   (id_wr_en),
    .id_rd      (id_rd),
    .id_is_load (id_is_load),
    .ex_flush   (ex_flush),
    .stall      (stall),
    .fwd_sel_a  (fwd_sel_a),
    .fwd_sel_b  (fwd_sel_b)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ins(input logic v, input logic [RB-1:0] rs1, input logic u1,
                     input logic [RB-1:0] rs2, input logic u2,
                     input logic wr, input logic [RB-1:0] rd, input logic ld);
    id_valid   = v;
    id_rs1     = rs1;
    id_use_rs1 = u1;
    id_rs2     = rs2;
    id_use_rs2 = u2;
    id_wr_en   = wr;
    id_rd      = rd;
    id_is_load = ld;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic nops(input int n);
    ins(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    ex_flush = 1'b0;
    reset    = 1'b1;
    // Reset held with a live producer of r1 and random sources
    ins(1'b1, RB'($urandom), 1'b1, RB'($urandom), 1'b1, 1'b1, 4'd1, 1'b0);
    tick();
    ins(1'b1, RB'($urandom), 1'b1, RB'($urandom), 1'b1, 1'b1, 4'd1, 1'b0);
    tick();
    chk("reset_stall", {3'd0, stall}, 4'd0);
    chk("reset_sel_a", {2'd0, fwd_sel_a}, 4'd0);
    chk("reset_sel_b", {2'd0, fwd_sel_b}, 4'd0);
    reset = 1'b0;
    // First post-reset instruction reads r1: nothing survived reset
    ins(1'b1, 4'd1, 1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0);
    tick();
    chk("post_reset_a", {2'd0, fwd_sel_a}, 4'd0);
    chk("post_reset_b", {2'd0, fwd_sel_b}, 4'd0);
    nops(4);

    // ADD r3; SUB rs1=r3 -> 1
    ins(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0); tick();
    ins(1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b1, 4'd8, 1'b0); tick();
    chk("adj_a", {2'd0, fwd_sel_a}, 4'd1);
    chk("adj_b", {2'd0, fwd_sel_b}, 4'd0);
    nops(4);

    // ADD r3; unrelated; reader -> 2
    ins(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0); tick();
    ins(1'b1, 4'd8, 1'b1, 4'd9, 1'b1, 1'b1, 4'd7, 1'b0); tick();
    ins(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0); tick();
    chk("gap1_a", {2'd0, fwd_sel_a}, 4'd2);
    nops(4);

    // ADD r3; two unrelated; reader -> 3 (or 0 without post entry)
    ins(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0); tick();
    ins(1'b1, 4'd8, 1'b1, 4'd9, 1'b1, 1'b1, 4'd7, 1'b0); tick();
    ins(1'b1, 4'd8, 1'b1, 4'd9, 1'b1, 1'b1, 4'd11, 1'b0); tick();
    ins(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0); tick();
    chk("gap2_a", {2'd0, fwd_sel_a}, {2'd0, EXP_POST});
    nops(4);

    // LW r5; ADD rs2=r5 -> stall one cycle, bubble, then 2
    ins(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b1); tick();
    ins(1'b1, 4'd1, 1'b1, 4'd5, 1'b1, 1'b1, 4'd10, 1'b0);
    #1;
    chk("lu_stall", {3'd0, stall}, 4'd1);
    tick();
    chk("lu_bubble_a", {2'd0, fwd_sel_a}, 4'd0);
    chk("lu_bubble_b", {2'd0, fwd_sel_b}, 4'd0);
    chk("lu_stall_drop", {3'd0, stall}, 4'd0);
    tick();
    chk("lu_fwd_a", {2'd0, fwd_sel_a}, 4'd0);
    chk("lu_fwd_b", {2'd0, fwd_sel_b}, 4'd2);
    nops(4);

    // ADD r4 x3; reader rs1=rs2=r4 -> youngest (1) on both
    ins(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd4, 1'b0); tick();
    tick();
    tick();
    ins(1'b1, 4'd4, 1'b1, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0); tick();
    chk("young_a", {2'd0, fwd_sel_a}, 4'd1);
    chk("young_b", {2'd0, fwd_sel_b}, 4'd1);
    nops(4);

    // Producer of r0 never forwards; LW r0 never stalls
    ins(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0); tick();
    ins(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0); tick();
    chk("r0_a", {2'd0, fwd_sel_a}, 4'd0);
    chk("r0_b", {2'd0, fwd_sel_b}, 4'd0);
    nops(4);
    ins(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd0, 1'b1); tick();
    ins(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
    #1;
    chk("r0_load_stall", {3'd0, stall}, 4'd0);
    tick();
    chk("r0_load_a", {2'd0, fwd_sel_a}, 4'd0);
    nops(4);

    // LW r6 then flush with a load-use reader: no stall, zero selects,
    // and the killed load never forwards to a later reader
    ins(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd6, 1'b1); tick();
    ins(1'b1, 4'd6, 1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0);
    ex_flush = 1'b1;
    #1;
    chk("flush_stall", {3'd0, stall}, 4'd0);
    tick();
    chk("flush_sel_a", {2'd0, fwd_sel_a}, 4'd0);
    chk("flush_sel_b", {2'd0, fwd_sel_b}, 4'd0);
    ex_flush = 1'b0;
    tick();
    chk("flush_killed_a", {2'd0, fwd_sel_a}, 4'd0);
    nops(4);

    // Use bit clear on rs1 while rs2 (same reg) is used
    ins(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd9, 1'b0); tick();
    ins(1'b1, 4'd9, 1'b0, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0); tick();
    chk("nouse_a", {2'd0, fwd_sel_a}, 4'd0);
    chk("nouse_b", {2'd0, fwd_sel_b}, 4'd1);
    nops(4);

    // Invalid ID slot gives zero selects even on a match
    ins(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd9, 1'b0); tick();
    ins(1'b0, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0); tick();
    chk("invalid_a", {2'd0, fwd_sel_a}, 4'd0);
    chk("invalid_b", {2'd0, fwd_sel_b}, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
